// File: rtl/breathing_light_array.sv
// breathing_light_array
//   Drives CH LEDs with phase-staggered triangle-wave PWM breathing. A
//   debounced button steps the block through OFF -> BREATHE -> BLINK -> SOLID.
//
//   Parameters
//     CH       number of LED channels (1..16)
//     PWM_W    PWM counter width; brightness 0..MAX, MAX = 2^PWM_W-1
//     STEP_DIV PWM periods per brightness step (>=1)
//   Ports
//     clk      system clock
//     rst      asynchronous active-high reset
//     btn      debounced button level, synchronous to clk
//     light    registered LED drive, one bit per channel
//     mode     registered mode: 0 OFF, 1 BREATHE, 2 BLINK, 3 SOLID
//
//   breathing_light_lane computes the next light bit for one channel from the
//   shared counters; the top holds the counters, the mode FSM and the output
//   register.

module breathing_light_lane #(
    parameter int PWM_W = 8,
    parameter int CH    = 4,
    parameter int IDX   = 0
) (
    input  logic [PWM_W:0]   ph,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [1:0]       mode,
    output logic             light_nxt
);
    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_BREATHE = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_SOLID   = 2'd3;

    localparam int            OFS    = (2 ** (PWM_W + 1)) / CH;
    localparam logic [PWM_W:0] PH_OFS = (PWM_W + 1)'(IDX * OFS);
    localparam logic           ODD    = ((IDX % 2) != 0) ? 1'b1 : 1'b0;

    logic [PWM_W:0]   p;
    logic [PWM_W-1:0] lvl;

    // Phase wraps naturally in PWM_W+1 bits; upper half mirrors the ramp
    // (MAX - x is the bitwise inverse for an all-ones MAX).
    assign p   = ph + PH_OFS;
    assign lvl = p[PWM_W] ? ~p[PWM_W-1:0] : p[PWM_W-1:0];

    always_comb begin
        light_nxt = 1'b0;
        case (mode)
            MODE_OFF:     light_nxt = 1'b0;
            MODE_BREATHE: light_nxt = (pwm_cnt < lvl);
            MODE_BLINK:   light_nxt = ph[PWM_W] ^ ODD;
            MODE_SOLID:   light_nxt = 1'b1;
            default:      light_nxt = 1'b0;
        endcase
    end
endmodule

module breathing_light_array #(
    parameter int CH       = 4,
    parameter int PWM_W    = 8,
    parameter int STEP_DIV = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn,
    output logic [CH-1:0] light,
    output logic [1:0]    mode
);
    localparam logic [1:0] MODE_BREATHE = 2'd1;

    localparam int                DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_TOP = DIV_W'(STEP_DIV - 1);
    localparam logic [PWM_W-1:0]  PWM_TOP = {PWM_W{1'b1}};

    logic [PWM_W-1:0] pwm_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [PWM_W:0]   ph;
    logic             btn_q;
    logic             adv;
    logic [CH-1:0]    light_nxt;

    assign adv = btn & ~btn_q;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        breathing_light_lane #(
            .PWM_W (PWM_W),
            .CH    (CH),
            .IDX   (i)
        ) u_lane (
            .ph        (ph),
            .pwm_cnt   (pwm_cnt),
            .mode      (mode),
            .light_nxt (light_nxt[i])
        );
    end

    // btn_q resets high so a button held through reset does not count as a
    // press. A mode step clears all counters and takes priority over wraps,
    // so every mode starts at phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
            ph      <= '0;
            btn_q   <= 1'b1;
            mode    <= MODE_BREATHE;
            light   <= '0;
        end else begin
            btn_q <= btn;
            light <= light_nxt;
            if (adv) begin
                mode    <= mode + 2'd1;
                pwm_cnt <= '0;
                div_cnt <= '0;
                ph      <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == PWM_TOP) begin
                    if (div_cnt == DIV_TOP) begin
                        div_cnt <= '0;
                        ph      <= ph + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_breathing_light_array.sv
// Directed bench for breathing_light_array with CH=4, PWM_W=3, STEP_DIV=2
// (OFS=4, MAX=7, ph steps every 16 clocks, full breath 256 clocks).
module tb_breathing_light_array;
    logic       clk;
    logic       rst;
    logic       btn;
    logic [3:0] light;
    logic [1:0] mode;

    int checks;
    int errors;
    int m;        // clock edges since counters last restarted from zero
    int cnt [4];

    breathing_light_array #(
        .CH       (4),
        .PWM_W    (3),
        .STEP_DIV (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .light (light),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        m++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-cycle PWM period of light, high count per channel.
    task automatic measure;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        repeat (8) begin
            tick();
            for (int i = 0; i < 4; i++) cnt[i] += int'(light[i]);
        end
    endtask

    task automatic expect_period(input string tag, input int e0, input int e1,
                                 input int e2, input int e3);
        measure();
        chk({tag, "_ch0"}, cnt[0], e0);
        chk({tag, "_ch1"}, cnt[1], e1);
        chk({tag, "_ch2"}, cnt[2], e2);
        chk({tag, "_ch3"}, cnt[3], e3);
    endtask

    // One-cycle press: mode must still be old before the edge, new after it.
    task automatic press(input string tag, input logic [1:0] old_m, input logic [1:0] new_m);
        btn = 1'b1;
        chk({tag, "_before"}, mode, old_m);
        tick();
        chk({tag, "_after"}, mode, new_m);
        m   = 0;
        btn = 1'b0;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        btn    = 1'b0;
        checks = 0;
        errors = 0;
        m      = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_light", light, 4'b0000);
        chk("rst_mode", mode, 2'd1);
        chk("rst_ph", dut.ph, 4'd0);
        rst = 1'b0;
        m   = 0;

        // Breathe through one full cycle, one measured period per ph value
        for (int p = 0; p < 16; p++) begin
            measure();
            chk("breathe_mode", mode, 2'd1);
            if (p == 0) begin
                chk("ph0_ch0", cnt[0], 0);
                chk("ph0_ch1", cnt[1], 4);
                chk("ph0_ch2", cnt[2], 7);
                chk("ph0_ch3", cnt[3], 3);
            end
            if (p == 1) begin
                chk("ph1_ch0", cnt[0], 1);
                chk("ph1_ch1", cnt[1], 5);
                chk("ph1_ch2", cnt[2], 6);
                chk("ph1_ch3", cnt[3], 2);
            end
            if (p == 7 || p == 8) chk("peak_ch0", cnt[0], 7);
            if (p == 15) chk("ph15_ch0", cnt[0], 0);
            repeat (8) tick();
            if (p == 0) chk("ph_step", dut.ph, 4'd1);
        end
        chk("wrap_ph", dut.ph, 4'd0);
        expect_period("wrap", 0, 4, 7, 3);

        // Mode cycling
        repeat (10) tick();
        press("to_blink", 2'd1, 2'd2);
        tick();
        chk("blink_first", light, 4'b1010);
        while (m < 128) tick();
        chk("blink_last_lo", light, 4'b1010);
        tick();
        chk("blink_flip", light, 4'b0101);
        repeat (9) tick();
        press("to_solid", 2'd2, 2'd3);
        tick();
        chk("solid", light, 4'b1111);
        repeat (9) tick();
        press("to_off", 2'd3, 2'd0);
        tick();
        chk("off", light, 4'b0000);
        repeat (9) tick();
        press("to_breathe", 2'd0, 2'd1);
        expect_period("rebreathe", 0, 4, 7, 3);

        // Held button: single step
        btn = 1'b1;
        tick();
        chk("hold_step", mode, 2'd2);
        m = 0;
        repeat (49) tick();
        chk("hold_stay", mode, 2'd2);
        btn = 1'b0;
        // Press landing on the edge where pwm_cnt and div_cnt both wrap
        while (m < 63) tick();
        chk("coinc_pwm", dut.pwm_cnt, 3'd7);
        chk("coinc_div", dut.div_cnt, 1'b1);
        btn = 1'b1;
        tick();
        chk("coinc_mode", mode, 2'd3);
        chk("coinc_ph", dut.ph, 4'd0);
        chk("coinc_pwm_clr", dut.pwm_cnt, 3'd0);
        repeat (20) tick();
        chk("hold2_stay", mode, 2'd3);
        btn = 1'b0;
        tick();

        // Button held through reset release
        btn = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_mode_a", mode, 2'd1);
        chk("arst_light_a", light, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        m   = 0;
        repeat (5) tick();
        chk("held_rst_mode", mode, 2'd1);
        btn = 1'b0;
        tick();
        press("rst_to_blink", 2'd1, 2'd2);
        repeat (3) tick();
        chk("pre_rst_blink", light, 4'b1010);
        // Async reset mid-BLINK
        rst = 1'b1;
        #1;
        chk("arst_light", light, 4'b0000);
        chk("arst_mode", mode, 2'd1);
        tick();
        rst = 1'b0;
        m   = 0;
        expect_period("post_rst", 0, 4, 7, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
